phy_tx_ms: RTL
==============

PHY_TX_MS -- requirements
Module: phy_tx_ms

Interface
REQ-001 SHALL have parameter BIT_SAMPLES, default 4, clk_i cycles per full-speed bit (clk_i = 12 MHz * BIT_SAMPLES).
REQ-002 SHALL have parameter LS_DIV, default 8, low-speed bit period multiplier (LS bit = BIT_SAMPLES*LS_DIV cycles).
REQ-003 SHALL have port clk_i  input  1  single clock for all logic.
REQ-004 SHALL have port rstn_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_valid_i  input  1  SIE requests or continues a packet; low after last byte consumed.
REQ-006 SHALL have port tx_data_i  input  8  byte to send, LSB first; held stable until consumed.
REQ-007 SHALL have port tx_ready_o  output  1  one-cycle pulse: tx_data_i consumed.
REQ-008 SHALL have port ls_i  input  1  speed select (1 = low speed), sampled only when leaving IDLE.
REQ-009 SHALL have port force_k_i  input  1  resume/K signalling request while idle.
REQ-010 SHALL have port tx_en_o  output  1  output driver enable.
REQ-011 SHALL have ports dp_tx_o, dn_tx_o  output  1 each  line levels, changing on the same clk_i edge.
REQ-012 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL use states IDLE, SYNC, DATA, STUFF_END, EOP_SE0, EOP_J, FORCE_K.
REQ-014 SHALL generate a bit tick every BIT_SAMPLES cycles (FS) or BIT_SAMPLES*LS_DIV cycles (LS); tick counter held at 0 in IDLE, restarted on leaving IDLE; state, bit, and NRZI updates occur only on ticks, except IDLE exits.
REQ-015 SHALL latch ls_i into an internal mode bit on IDLE exit; mode constant until next IDLE entry.
REQ-016 SHALL map J = (dp=1, dn=0) in FS and (dp=0, dn=1) in LS; K is the inverse; SE0 = (0, 0).
REQ-017 IDLE: tx_en_o=0, lines at J of the last mode; on tx_valid_i=1 go to SYNC next cycle; else on force_k_i=1 go to FORCE_K; tx_valid_i wins if both are high.
REQ-018 SYNC: send 8 bits 0000_0001 (LSB first, line pattern KJKJKJKK); each bit lasts one full bit period from IDLE exit.
REQ-019 At each byte boundary (last SYNC bit or last DATA bit tick): if tx_valid_i=1, load tx_data_i and pulse tx_ready_o for exactly one cycle; else go to EOP_SE0, via STUFF_END if a stuff bit is pending.
REQ-020 NRZI: a 0 bit toggles the line; a 1 bit holds it.
REQ-021 Bit stuffing: after 6 consecutive 1 bits, SHALL insert one 0 bit (toggle) before the next data bit; the counter resets on any 0 and after the stuff bit; SYNC bits count toward the run.
REQ-022 A stuffed bit SHALL not advance the bit count or the data shift; tx_ready_o timing shifts one bit period accordingly.
REQ-023 STUFF_END: send the pending stuff bit after the final data bit, then go to EOP_SE0.
REQ-024 EOP_SE0: drive SE0 for exactly 2 bit periods; EOP_J: drive J for 1 bit period; then go to IDLE with tx_en_o=0.
REQ-025 FORCE_K: tx_en_o=1, drive K; on force_k_i=0, go to EOP_SE0 if ls_mode=1 (LS resume ends with EOP), else straight to EOP_J.
REQ-026 tx_valid_i rising during EOP_SE0/EOP_J/FORCE_K SHALL be ignored until IDLE is reached; the packet then starts from IDLE.
REQ-027 tx_ready_o SHALL never assert outside SYNC/DATA boundary ticks, and never twice for one byte.

Reset
REQ-028 With rstn_i=0 at a clk_i edge: state IDLE, tx_en_o=0, dp_tx_o=1, dn_tx_o=0, tx_ready_o=0, busy_o=0, mode=FS, stuff count=0, tick counter=0.
REQ-029 Reset mid-packet SHALL abort immediately at the next edge with no EOP; rstn_i has no asynchronous effect.

Verification
REQ-030 FS, BIT_SAMPLES=4, one byte 0xA5 -> tx_en_o high 1 cycle after tx_valid_i; SYNC KJKJKJKK at 4 cycles/bit; one tx_ready_o pulse; 8 NRZI bits; SE0 8 cycles; J 4 cycles; tx_en_o low.
REQ-031 FS byte 0xFF then 0xFF -> stuff bit after every 6 ones, including a carry-over from SYNC's final 1; STUFF_END used if the last stuff bit is pending; second tx_ready_o pulse delayed by one bit period.
REQ-032 LS, LS_DIV=8, byte 0x00 -> 32 cycles/bit; dp/dn polarity inverted versus FS; SE0 64 cycles.
REQ-033 force_k_i high 100 cycles in FS idle -> K (dp=0, dn=1) for the request duration, then J 4 cycles, then IDLE; in LS mode SE0 64 cycles precedes J.
REQ-034 rstn_i low during DATA bit 3 -> next edge tx_en_o=0, dp=1, dn=0, busy_o=0; a new tx_valid_i afterwards starts a clean SYNC.

Source files
------------

// File: rtl/phy_tx_ms_if.sv
// SIE <-> USB transmit PHY bundle: byte handshake, mode/resume requests and line drive.
interface phy_tx_ms_if;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       ls_i;
    logic       force_k_i;
    logic       tx_en_o;
    logic       dp_tx_o;
    logic       dn_tx_o;
    logic       busy_o;

    modport master (
        output tx_valid_i, tx_data_i, ls_i, force_k_i,
        input  tx_ready_o, tx_en_o, dp_tx_o, dn_tx_o, busy_o
    );
    modport slave (
        input  tx_valid_i, tx_data_i, ls_i, force_k_i,
        output tx_ready_o, tx_en_o, dp_tx_o, dn_tx_o, busy_o
    );
endinterface

// File: rtl/phy_tx_ms.sv
// USB FS/LS transmit PHY: SYNC, NRZI with bit stuffing, EOP and resume-K signalling.
module phy_tx_ms #(
    parameter int BIT_SAMPLES = 4,
    parameter int LS_DIV      = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    phy_tx_ms_if.slave bus
);
    localparam int FS_P = BIT_SAMPLES;
    localparam int LS_P = BIT_SAMPLES * LS_DIV;
    localparam int CW   = $clog2(LS_P + 1);
    // SYNC is 0x80 LSB first; its first bit goes out on IDLE exit, so the rest is preloaded
    localparam logic [7:0] SYNC_REST = 8'h40;

    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, STUFF_END, EOP_SE0, EOP_J, FORCE_K
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sent_q, sent_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    ones_q, ones_d;
    logic          ls_q, ls_d;
    logic          tx_en_q, tx_en_d;
    logic          ready_q, ready_d;
    logic          dp_q, dp_d;
    logic          dn_q, dn_d;
    logic          tick;
    logic [7:0]    nb;
    logic [3:0]    ns;
    logic          stuff;

    assign tick  = (cnt_q == (ls_q ? CW'(LS_P - 1) : CW'(FS_P - 1)));
    assign stuff = (ones_q == 3'd6);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        sent_d  = sent_q;
        shift_d = shift_q;
        ones_d  = ones_q;
        ls_d    = ls_q;
        tx_en_d = tx_en_q;
        ready_d = 1'b0;
        dp_d    = dp_q;
        dn_d    = dn_q;
        nb      = shift_q;
        ns      = sent_q;
        case (state_q)
            IDLE: begin
                tx_en_d = 1'b0;
                dp_d    = ~ls_q;
                dn_d    = ls_q;
                if (bus.tx_valid_i) begin
                    state_d = SYNC;
                    ls_d    = bus.ls_i;
                    tx_en_d = 1'b1;
                    dp_d    = bus.ls_i;
                    dn_d    = ~bus.ls_i;
                    shift_d = SYNC_REST;
                    sent_d  = 4'd1;
                    ones_d  = '0;
                end else if (bus.force_k_i) begin
                    state_d = FORCE_K;
                    ls_d    = bus.ls_i;
                    tx_en_d = 1'b1;
                    dp_d    = bus.ls_i;
                    dn_d    = ~bus.ls_i;
                end
            end
            SYNC, DATA: if (tick) begin
                if (sent_q == 4'd8) begin
                    if (bus.tx_valid_i) begin
                        nb      = bus.tx_data_i;
                        ns      = '0;
                        ready_d = 1'b1;
                        state_d = DATA;
                    end else if (stuff) begin
                        state_d = STUFF_END;
                        dp_d    = ~dp_q;
                        dn_d    = ~dn_q;
                        ones_d  = '0;
                    end else begin
                        state_d = EOP_SE0;
                        dp_d    = 1'b0;
                        dn_d    = 1'b0;
                        sent_d  = '0;
                    end
                end
                // A pending stuff bit goes out before the next data bit and leaves the shift untouched
                if (sent_q != 4'd8 || bus.tx_valid_i) begin
                    shift_d = stuff ? nb : nb >> 1;
                    sent_d  = stuff ? ns : ns + 4'd1;
                    ones_d  = (!stuff && nb[0]) ? ones_q + 3'd1 : 3'd0;
                    if (stuff || !nb[0]) begin
                        dp_d = ~dp_q;
                        dn_d = ~dn_q;
                    end
                end
            end
            STUFF_END: if (tick) begin
                state_d = EOP_SE0;
                dp_d    = 1'b0;
                dn_d    = 1'b0;
                sent_d  = '0;
            end
            EOP_SE0: if (tick) begin
                if (sent_q == 4'd1) begin
                    state_d = EOP_J;
                    dp_d    = ~ls_q;
                    dn_d    = ls_q;
                end else begin
                    sent_d = sent_q + 4'd1;
                end
            end
            EOP_J: if (tick) begin
                state_d = IDLE;
                tx_en_d = 1'b0;
            end
            FORCE_K: if (tick && !bus.force_k_i) begin
                // LS resume terminates with a full EOP; FS returns straight to J
                if (ls_q) begin
                    state_d = EOP_SE0;
                    dp_d    = 1'b0;
                    dn_d    = 1'b0;
                    sent_d  = '0;
                end else begin
                    state_d = EOP_J;
                    dp_d    = ~ls_q;
                    dn_d    = ls_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sent_q  <= '0;
            shift_q <= '0;
            ones_q  <= '0;
            ls_q    <= 1'b0;
            tx_en_q <= 1'b0;
            ready_q <= 1'b0;
            dp_q    <= 1'b1;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            shift_q <= shift_d;
            ones_q  <= ones_d;
            ls_q    <= ls_d;
            tx_en_q <= tx_en_d;
            ready_q <= ready_d;
            dp_q    <= dp_d;
            dn_q    <= dn_d;
        end
    end

    assign bus.tx_ready_o = ready_q;
    assign bus.tx_en_o    = tx_en_q;
    assign bus.dp_tx_o    = dp_q;
    assign bus.dn_tx_o    = dn_q;
    assign bus.busy_o     = (state_q != IDLE);
endmodule
